async_fifo: RTL and testbench
=============================

// Module: async_fifo
// PURPOSE
//  Dual-clock FIFO carrying DATA_WIDTH words from a write clock domain to a read clock domain.
//  Storage is 2**ADDR_WIDTH words. Pointers cross domains as Gray code through flop synchronisers.
//  The read side is first-word-fall-through: the head word is presented on rdata without a pull.
//  Used for CDC buffering between pipeline or bus blocks running on unrelated clocks.
// PARAMETERS
//  DATA_WIDTH   32  width of each stored word
//  ADDR_WIDTH   4   log2 of depth; depth = 1<<ADDR_WIDTH = 16 words
//  SYNC_STAGES  2   flop stages in each pointer synchroniser (>=2)
// PORTS
//  Clocking/reset: one clock per side (wclk for write logic, rclk for read logic, no other clock).
//  Reset is asynchronous and active-low (wrst_n, rrst_n).
//  wclk    in   1           write-domain clock
//  wrst_n  in   1           write-domain reset
//  rclk    in   1           read-domain clock
//  rrst_n  in   1           read-domain reset
//  wpush   in   1           write request, sampled on posedge wclk
//  wdata   in   DATA_WIDTH  write data, sampled with wpush
//  wfull   out  1           FIFO full (wclk domain, registered)
//  rpull   in   1           pop request, sampled on posedge rclk
//  rdata   out  DATA_WIDTH  head-of-queue word (combinational from memory at read address)
//  rempty  out  1           FIFO empty (rclk domain, registered)
// BEHAVIOUR
//  - Pointers wptr/rptr are ADDR_WIDTH+1 bits, binary plus Gray copies.
//    The low ADDR_WIDTH bits address memory; the MSB is the wrap bit.
//  - Write: on posedge wclk with wpush && !wfull, mem[waddr] <= wdata and wptr increments.
//    A push while wfull is ignored: no write, no pointer change.
//  - Read: on posedge rclk with rpull && !rempty, rptr increments.
//    A pull while rempty is ignored.
//  - rdata = mem[raddr] at all times; the next word appears combinationally after each pop.
//  - Gray wptr is synchronised into rclk over SYNC_STAGES flops (reset by rrst_n).
//    Gray rptr is synchronised into wclk the same way (reset by wrst_n).
//  - rempty <= (rgray_next == synced wgray). Asserts in the same edge the last word is popped.
//  - wfull <= (wgray_next == synced rgray with its two MSBs inverted).
//    Asserts in the same edge the 16th word is written.
//  - Flags are pessimistic. A write is visible to the reader (rempty deasserts) 2-3 rclk edges later.
//    A pop frees space (wfull deasserts) 2-3 wclk edges later.
//  - Simultaneous push and pull in their own domains are independent and always legal.
//  - Wrap-around: pointers roll over modulo 2**(ADDR_WIDTH+1); order is preserved across wrap.
//  - Reset values: wptr=0 and wfull=0 on wrst_n low; rptr=0 and rempty=1 on rrst_n low.
//    Synchroniser flops clear with their domain's reset.
//  - Memory is not reset. Both resets are asserted together to restart the FIFO.
//    Resetting one side mid-operation leaves the contents undefined.
// CONFIGURATION
//  ASYNCFIFO_ZERO_ON_EMPTY_EN defined: rdata is forced to 0 whenever rempty=1.
//  Not defined: rdata shows mem[raddr] even when empty (stale data, don't-care).
// TESTING
//  1. Reset: hold both resets low 2 cycles -> rempty=1, wfull=0 during and after reset.
//  2. Stream: push 16 words 2..17, one every other wclk (wclk period 2x rclk);
//     pull whenever !rempty -> 2..17 received in order, no loss or duplicate.
//  3. Fill: push 16 words 20..35 with no pulls -> wfull=1 after the 16th push;
//     a 17th push is ignored.
//  4. Drain and refill: push 20 words 20..39, pulls starting after 15 pushes;
//     check rdata before each pop -> 20..39 in order across pointer wrap; rempty=1 at end.
//  5. Empty pull: rpull=1 while rempty=1 -> rptr unchanged, rempty stays 1.
//     With ASYNCFIFO_ZERO_ON_EMPTY_EN, rdata=0.
//  6. Mid-run reset: after 5 pushes, pulse both resets -> rempty=1, wfull=0;
//     subsequent push of 0xA5 is read back as 0xA5.

Source files
------------

// File: rtl/async_fifo.sv
// rtl/async_fifo.sv - dual-clock FIFO, Gray-coded pointer crossing, first-word-fall-through read side
// Optional feature macro: ASYNCFIFO_ZERO_ON_EMPTY_EN (rdata forced to zero while rempty)
module async_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  wpush,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    input  logic                  rpull,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // write domain
    logic [PW-1:0]                  r_wbin;
    logic [PW-1:0]                  r_wgray;
    logic                           r_wfull;
    logic [SYNC_STAGES-1:0][PW-1:0] r_rgray_sync;
    logic                           w_wen;
    logic [PW-1:0]                  w_wbin_next;
    logic [PW-1:0]                  w_wgray_next;
    logic [PW-1:0]                  w_rgray_wclk;
    logic [PW-1:0]                  w_full_cmp;

    // read domain
    logic [PW-1:0]                  r_rbin;
    logic [PW-1:0]                  r_rgray;
    logic                           r_rempty;
    logic [SYNC_STAGES-1:0][PW-1:0] r_wgray_sync;
    logic                           w_ren;
    logic [PW-1:0]                  w_rbin_next;
    logic [PW-1:0]                  w_rgray_next;
    logic [DATA_WIDTH-1:0]          w_rdata_mem;

    assign w_wen        = wpush && !r_wfull;
    assign w_wbin_next  = r_wbin + {{ADDR_WIDTH{1'b0}}, w_wen};
    assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;
    assign w_rgray_wclk = r_rgray_sync[SYNC_STAGES-1];
    // Full when the write pointer is exactly one lap ahead: Gray form flips the two MSBs.
    assign w_full_cmp   = {~w_rgray_wclk[PW-1:PW-2], w_rgray_wclk[PW-3:0]};

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin       <= '0;
            r_wgray      <= '0;
            r_wfull      <= 1'b0;
            r_rgray_sync <= '0;
        end else begin
            r_wbin       <= w_wbin_next;
            r_wgray      <= w_wgray_next;
            r_wfull      <= (w_wgray_next == w_full_cmp);
            r_rgray_sync <= {r_rgray_sync[SYNC_STAGES-2:0], r_rgray};
        end
    end

    always_ff @(posedge wclk) begin
        if (w_wen) begin
            r_mem[r_wbin[ADDR_WIDTH-1:0]] <= wdata;
        end
    end

    assign w_ren        = rpull && !r_rempty;
    assign w_rbin_next  = r_rbin + {{ADDR_WIDTH{1'b0}}, w_ren};
    assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rbin       <= '0;
            r_rgray      <= '0;
            r_rempty     <= 1'b1;
            r_wgray_sync <= '0;
        end else begin
            r_rbin       <= w_rbin_next;
            r_rgray      <= w_rgray_next;
            r_rempty     <= (w_rgray_next == r_wgray_sync[SYNC_STAGES-1]);
            r_wgray_sync <= {r_wgray_sync[SYNC_STAGES-2:0], r_wgray};
        end
    end

    assign w_rdata_mem = r_mem[r_rbin[ADDR_WIDTH-1:0]];

`ifdef ASYNCFIFO_ZERO_ON_EMPTY_EN
    assign rdata = r_rempty ? '0 : w_rdata_mem;
`else
    assign rdata = w_rdata_mem;
`endif

    assign wfull  = r_wfull;
    assign rempty = r_rempty;

endmodule

// File: tb/tb_async_fifo.sv
// tb/tb_async_fifo.sv - self-checking bench for async_fifo against a queue reference model
module tb_async_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          wclk = 1'b0;
    logic          rclk = 1'b0;
    logic          wrst_n = 1'b1;
    logic          rrst_n = 1'b1;
    logic          wpush = 1'b0;
    logic          rpull = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          wfull;
    logic          rempty;

    int            errors = 0;
    int            checks = 0;
    int            wr_count = 0;
    logic [DW-1:0] model_q[$];

    always #10 wclk = ~wclk;
    always #5  rclk = ~rclk;

    async_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(4), .SYNC_STAGES(2)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .rclk(rclk), .rrst_n(rrst_n),
        .wpush(wpush), .wdata(wdata), .wfull(wfull),
        .rpull(rpull), .rdata(rdata), .rempty(rempty)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge wclk);
        wpush = 1'b0; rpull = 1'b0;
        wrst_n = 1'b0; rrst_n = 1'b0;
        #1;
        check({tag, "_rempty_in_rst"}, rempty, 1);
        check({tag, "_wfull_in_rst"}, wfull, 0);
        repeat (2) @(negedge wclk);
        check({tag, "_rempty_end_rst"}, rempty, 1);
        wrst_n = 1'b1; rrst_n = 1'b1;
        model_q.delete();
        wr_count = 0;
        repeat (3) @(negedge wclk);
        check({tag, "_rempty_after"}, rempty, 1);
        check({tag, "_wfull_after"}, wfull, 0);
    endtask

    // Pushes n words (base+i or random), waiting out wfull; gap idles wclk cycles between pushes.
    task automatic writer(input int n, input logic [DW-1:0] base, input bit rnd,
                          input int gap_max, input string tag);
        logic [DW-1:0] d;
        int            cyc;
        for (int i = 0; i < n; i++) begin
            d = rnd ? DW'($urandom) : base + DW'(i);
            cyc = 0;
            @(negedge wclk);
            while (wfull && cyc < 400) begin
                @(negedge wclk);
                cyc++;
            end
            if (cyc >= 400) check({tag, "_wfull_stuck"}, wfull, 0);
            wdata = d;
            wpush = 1'b1;
            @(posedge wclk);
            #1 wpush = 1'b0;
            model_q.push_back(d);
            wr_count++;
            repeat (rnd ? $urandom_range(gap_max) : gap_max) @(posedge wclk);
        end
    endtask

    // Pops n words, comparing the fall-through head against the model before each pop.
    task automatic reader(input int n, input int budget, input int stall_pct, input string tag);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < budget) begin
            @(negedge rclk);
            cyc++;
            if (model_q.size() == 0) check({tag, "_empty_when_model_empty"}, rempty, 1);
            if (!rempty && ($urandom_range(99) >= stall_pct)) begin
                check({tag, "_model_has_word"}, model_q.size() != 0, 1);
                if (model_q.size() != 0) check({tag, "_rdata"}, rdata, model_q.pop_front());
                rpull = 1'b1;
                got++;
            end else begin
                rpull = 1'b0;
            end
        end
        @(posedge rclk);
        #1 rpull = 1'b0;
        check({tag, "_count"}, got, n);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        // Reset
        do_reset("reset");

        // Stream 2..17, one push every other wclk, pull whenever data is present
        fork
            writer(16, 32'd2, 1'b0, 1, "stream_w");
            reader(16, 2000, 0, "stream");
        join
        check("stream_model_drained", model_q.size(), 0);

        // Fill 20..35 with no pulls; wfull rises exactly on the 16th write
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge wclk);
            check("fill_not_full_before", wfull, 0);
            wdata = 32'd20 + DW'(i);
            wpush = 1'b1;
            @(posedge wclk);
            #1 wpush = 1'b0;
            model_q.push_back(32'd20 + DW'(i));
            if (i == DEPTH - 2) check("fill_not_full_15", wfull, 0);
        end
        check("fill_full_16", wfull, 1);
        @(negedge wclk);
        wdata = 32'hDEAD_BEEF;
        wpush = 1'b1;
        @(posedge wclk);
        #1 wpush = 1'b0;
        check("fill_full_after_17th", wfull, 1);
        reader(16, 1000, 0, "fill_drain");
        repeat (8) @(negedge rclk);
        check("fill_rempty_end", rempty, 1);
        repeat (6) @(negedge wclk);
        check("fill_wfull_released", wfull, 0);

        // Drain and refill across pointer wrap: 20..39, pulls start after 15 pushes
        wr_count = 0;
        fork
            writer(20, 32'd20, 1'b0, 0, "wrap_w");
            begin
                cyc = 0;
                while (wr_count < 15 && cyc < 2000) begin
                    @(negedge rclk);
                    cyc++;
                end
                check("wrap_start_seen", wr_count >= 15, 1);
                reader(20, 2000, 0, "wrap");
            end
        join
        repeat (8) @(negedge rclk);
        check("wrap_rempty_end", rempty, 1);

        // Pull while empty is ignored
        for (int i = 0; i < 5; i++) begin
            @(negedge rclk);
            rpull = 1'b1;
            @(posedge rclk);
            #1;
            check("empty_pull_rempty", rempty, 1);
`ifdef ASYNCFIFO_ZERO_ON_EMPTY_EN
            check("empty_pull_rdata_zero", rdata, 0);
`endif
        end
        rpull = 1'b0;
        writer(1, 32'h0000_1234, 1'b0, 0, "empty_pull_w");
        reader(1, 100, 0, "empty_pull_after");

        // Random data, random gaps and random reader stalls, overfilling the FIFO
        fork
            writer(48, '0, 1'b1, 3, "rand_w");
            reader(48, 6000, 60, "rand");
        join
        check("rand_model_drained", model_q.size(), 0);

        // Mid-run reset after 5 pushes, then a single word round-trip
        writer(5, 32'd50, 1'b0, 0, "midrst_w");
        do_reset("midrst");
        writer(1, 32'h0000_00A5, 1'b0, 0, "midrst_a5_w");
        reader(1, 100, 0, "midrst_a5");
        repeat (8) @(negedge rclk);
        check("midrst_rempty_end", rempty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
